// File: rtl/lsu_ctrl.sv
// Load/store unit between the execute stage and byte-addressed data_mem.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module lsu_ctrl #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wdata_mask,
  output logic              mem_wen,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic            err_q;
  logic            wen_q;
  logic            req_err_c;
  logic [3:0]      req_mask_c;
  logic [XLEN-1:0] load_ext_c;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[XLEN-1:AWIDTH];

  // Decode legality and store lane mask of the incoming request
  always_comb begin
    req_err_c  = 1'b0;
    req_mask_c = 4'b0000;
    if (req_we) begin
      case (req_funct3)
        F3_B:    req_mask_c = 4'b0001;
        F3_H:    req_mask_c = 4'b0011;
        F3_W:    req_mask_c = 4'b1111;
        default: req_err_c  = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: req_err_c = 1'b0;
        default:                        req_err_c = 1'b1;
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3)
      F3_H, F3_HU: if (req_addr[0])          req_err_c = 1'b1;
      F3_W:        if (req_addr[1:0] != 2'b00) req_err_c = 1'b1;
      default:     ;
    endcase
`endif
    if (req_err_c) req_mask_c = 4'b0000;
  end

  // Sign/zero extension of the raw memory word for the captured load width
  always_comb begin
    case (funct3_q)
      F3_B:    load_ext_c = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
      F3_H:    load_ext_c = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
      F3_BU:   load_ext_c = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
      F3_HU:   load_ext_c = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
      default: load_ext_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      err_q          <= 1'b0;
      wen_q          <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wdata_mask <= 4'b0000;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q           <= req_we;
            funct3_q       <= req_funct3;
            err_q          <= req_err_c;
            wen_q          <= req_we && !req_err_c;
            mem_addr       <= req_addr[AWIDTH-1:0];
            mem_wdata      <= req_wdata;
            mem_wdata_mask <= req_mask_c;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          wen_q          <= 1'b0;
          mem_wdata_mask <= 4'b0000;
          rsp_valid      <= 1'b1;
          rsp_err        <= err_q;
          rsp_rdata      <= (we_q || err_q) ? '0 : load_ext_c;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset must suppress a write even in the cycle it is first asserted
  assign mem_wen   = wen_q && !rst;
  assign req_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model behind it.
module tb_lsu_ctrl;
  localparam int unsigned AWIDTH = 8;
  localparam int unsigned XLEN   = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic [AWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_wdata_mask;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_rdata;

  int vectors;
  int miscompares;
  int wen_cnt;
  logic mem_clr;
  logic [7:0] mem [256];
  logic [7:0] a1, a2, a3;

  lsu_ctrl #(.AWIDTH(AWIDTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_mask(mem_wdata_mask),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read of addr..addr+3 with wrap, masked write on posedge
  always_comb begin
    a1 = mem_addr + 8'd1;
    a2 = mem_addr + 8'd2;
    a3 = mem_addr + 8'd3;
    mem_rdata = {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
  end

  initial wen_cnt = 0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (mem_wdata_mask[i]) mem[8'(mem_addr + 8'(i))] <= mem_wdata[8*i +: 8];
    end
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err, input logic [3:0] exp_mask);
    int n;
    int wc0;
    logic do_wr;
    do_wr = we && !exp_err;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    wc0 = wen_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_we = 1'b0;
    chk({tag, "_acc_wen"}, 32'(mem_wen), 32'(do_wr));
    chk({tag, "_acc_mask"}, 32'(mem_wdata_mask), 32'(exp_mask));
    chk({tag, "_acc_addr"}, 32'(mem_addr), 32'(addr[7:0]));
    if (do_wr) chk({tag, "_acc_wdata"}, mem_wdata, wd);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_wen_count"}, 32'(wen_cnt - wc0), 32'(do_wr));
  endtask

  initial begin
    int wc0;
    vectors = 0; miscompares = 0;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);
    chk("rst_mask", 32'(mem_wdata_mask), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_req_ready_idle", 32'(req_ready), 32'd1);

    xact("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 4'b1111);
    xact("lb_13",  1'b0, 3'b000, 32'h13, 32'h0,         0, 32'hFFFF_FFDE, 1'b0, 4'b0000);
    xact("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0,         0, 32'h0000_00DE, 1'b0, 4'b0000);
    xact("lh_12",  1'b0, 3'b001, 32'h12, 32'h0,         0, 32'hFFFF_DEAD, 1'b0, 4'b0000);
    xact("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0,         0, 32'h0000_DEAD, 1'b0, 4'b0000);
    xact("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, 4'b0000);
    xact("sb_11",  1'b1, 3'b000, 32'h11, 32'h0000_0055, 0, 32'h0,         1'b0, 4'b0001);
    xact("lw_10b", 1'b0, 3'b010, 32'h10, 32'h0,         0, 32'hDEAD_55EF, 1'b0, 4'b0000);
    xact("lw_hold", 1'b0, 3'b010, 32'h10, 32'h0,        3, 32'hDEAD_55EF, 1'b0, 4'b0000);
    xact("lw_hiaddr", 1'b0, 3'b010, 32'hFFFF_FF10, 32'h0, 0, 32'hDEAD_55EF, 1'b0, 4'b0000);
    xact("sh_40",  1'b1, 3'b001, 32'h40, 32'hABCD_1234, 0, 32'h0,         1'b0, 4'b0011);
    xact("lw_40",  1'b0, 3'b010, 32'h40, 32'h0,         0, 32'h0000_1234, 1'b0, 4'b0000);
    xact("s011_20", 1'b1, 3'b011, 32'h20, 32'hFFFF_FFFF, 0, 32'h0,        1'b1, 4'b0000);
    xact("lw_20",  1'b0, 3'b010, 32'h20, 32'h0,         0, 32'h0,         1'b0, 4'b0000);
    xact("l110_10", 1'b0, 3'b110, 32'h10, 32'h0,        0, 32'h0,         1'b1, 4'b0000);

    // Reset lands during the ACCESS cycle of a store
    @(negedge clk);
    wc0 = wen_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1 chk("rstmid_mem_wen", 32'(mem_wen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_wen_count", 32'(wen_cnt - wc0), 32'd0);
    xact("lw_30", 1'b0, 3'b010, 32'h30, 32'h0, 0, 32'h0, 1'b0, 4'b0000);

`ifdef LSU_MISALIGN_TRAP_EN
    xact("lw_11_mis", 1'b0, 3'b010, 32'h11, 32'h0, 0, 32'h0, 1'b1, 4'b0000);
    xact("sh_41_mis", 1'b1, 3'b001, 32'h41, 32'hFFFF_FFFF, 0, 32'h0, 1'b1, 4'b0000);
    xact("lw_40_chk", 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h0000_1234, 1'b0, 4'b0000);
`else
    xact("lw_11_mis", 1'b0, 3'b010, 32'h11, 32'h0, 0, 32'h00DE_AD55, 1'b0, 4'b0000);
    xact("sw_fe_wrap", 1'b1, 3'b010, 32'hFE, 32'hA1B2_C3D4, 0, 32'h0, 1'b0, 4'b1111);
    xact("lw_00_wrap", 1'b0, 3'b010, 32'h00, 32'h0, 0, 32'h0000_A1B2, 1'b0, 4'b0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
